// File: rtl/wishbone_irq_controller_pkg.sv
// Shared constants for the interrupt controller: address map, register
// offsets, bus widths and the register-window decode helper.
package wishbone_irq_controller_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  localparam logic [31:0] IRQC_START = 32'h0000_0000;
  localparam logic [31:0] IRQC_SIZE  = 32'h0000_0020;

  localparam logic [31:0] IRQC_PENDING   = 32'h00;
  localparam logic [31:0] IRQC_ENABLE    = 32'h04;
  localparam logic [31:0] IRQC_MODE      = 32'h08;
  localparam logic [31:0] IRQC_CLAIM     = 32'h0C;
  localparam logic [31:0] IRQC_INSERVICE = 32'h10;

  // Claim ids are 1-based, 0 means "nothing eligible"; 31 sources fit in 5 bits.
  localparam int IRQC_ID_W = 5;

  typedef enum logic [2:0] {
    REG_PENDING,
    REG_ENABLE,
    REG_MODE,
    REG_CLAIM,
    REG_INSERVICE,
    REG_NONE
  } reg_sel_t;

  // Map a window-relative byte offset onto a register; anything unmapped
  // (or outside the window) becomes REG_NONE, which still acks.
  function automatic reg_sel_t decode_reg(input logic [31:0] offset,
                                          input logic [31:0] size);
    reg_sel_t r;
    r = REG_NONE;
    if (offset < size) begin
      case (offset & ~32'h3)
        IRQC_PENDING:   r = REG_PENDING;
        IRQC_ENABLE:    r = REG_ENABLE;
        IRQC_MODE:      r = REG_MODE;
        IRQC_CLAIM:     r = REG_CLAIM;
        IRQC_INSERVICE: r = REG_INSERVICE;
        default:        r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/wishbone_irq_controller_if.sv
// Classic wishbone single-port bus bundle used by the interrupt controller.
interface wishbone_interface;
  import wishbone_irq_controller_pkg::*;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [WB_AW-1:0] adr;
  logic [WB_DW-1:0] dat_w;
  logic [WB_DW-1:0] dat_r;
  logic [WB_SW-1:0] sel;
  logic             ack;
  logic             err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wishbone_irq_controller_priority_encoder.sv
// Lowest-index-first priority encoder producing a 1-based id (0 = none).
module irq_priority_encoder
  import wishbone_irq_controller_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]     req,
  output logic [IRQC_ID_W-1:0] id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) id = IRQC_ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/wishbone_irq_controller.sv
// Interrupt controller: aggregates NUM_SOURCES request lines into one
// registered irq, with per-source enable, edge/level mode, pending and
// claim/complete tracking behind a never-stalling wishbone slave.
module wishbone_irq_controller
  import wishbone_irq_controller_pkg::*;
#(
  parameter logic [31:0] ADDRESS     = IRQC_START,
  parameter logic [31:0] SIZE        = IRQC_SIZE,
  parameter int          NUM_SOURCES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] sources,
  output logic                   irq,
  wishbone_interface.slave       wishbone
);

  localparam int N = NUM_SOURCES;

  logic [N-1:0] pending, enable, mode, in_service, prev;

  // Request captured on the cyc&stb cycle; side effects happen in the ack cycle.
  logic                 req_valid;
  logic                 req_we;
  reg_sel_t             req_reg;
  logic [N-1:0]         req_lane;
  logic [N-1:0]         req_wdat;
  logic [IRQC_ID_W-1:0] req_id;
  logic                 req_id_ok;

  logic [N-1:0]         lane;
  logic [31:0]          offset;
  logic                 req_hit;

  logic [N-1:0]         eligible, rise, w1c, mode_chg, pending_edge;
  logic [N-1:0]         claim_set, complete_clr;
  logic [N-1:0]         pending_next, enable_next, mode_next, in_service_next;
  logic [IRQC_ID_W-1:0] claim_id;
  logic                 claim_fire, complete_fire, irq_next;
  logic [31:0]          rdata;

  assign offset  = wishbone.adr - ADDRESS;
  assign req_hit = wishbone.cyc & wishbone.stb;

  // Expand the byte selects to one enable per source bit.
  always_comb begin
    lane = '0;
    for (int i = 0; i < N; i++) lane[i] = wishbone.sel[i / 8];
  end

  // Latch each request so it can be acked and applied on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_reg   <= REG_NONE;
      req_lane  <= '0;
      req_wdat  <= '0;
      req_id    <= '0;
      req_id_ok <= 1'b0;
    end else begin
      req_valid <= req_hit;
      if (req_hit) begin
        req_we    <= wishbone.we;
        req_reg   <= decode_reg(offset, SIZE);
        req_lane  <= lane;
        req_wdat  <= wishbone.dat_w[N-1:0] & lane;
        req_id    <= wishbone.dat_w[IRQC_ID_W-1:0];
        req_id_ok <= wishbone.sel[0];
      end
    end
  end

  assign eligible = pending & enable & ~in_service;

  irq_priority_encoder #(.WIDTH(N)) u_prio (
    .req (eligible),
    .id  (claim_id)
  );

  assign claim_fire    = req_valid & ~req_we & (req_reg == REG_CLAIM) & (claim_id != '0);
  assign complete_fire = req_valid & req_we & (req_reg == REG_CLAIM) & req_id_ok;

  // Decode claim/complete ids into per-source one-hot masks.
  always_comb begin
    claim_set    = '0;
    complete_clr = '0;
    for (int i = 0; i < N; i++) begin
      claim_set[i]    = claim_fire    && (claim_id == IRQC_ID_W'(i + 1));
      complete_clr[i] = complete_fire && (req_id   == IRQC_ID_W'(i + 1));
    end
  end

  // Next-state for the register file; irq is registered from the next state
  // so a change is visible on irq the cycle right after it takes effect.
  always_comb begin
    enable_next = enable;
    mode_next   = mode;
    w1c         = '0;
    if (req_valid && req_we) begin
      case (req_reg)
        REG_PENDING: w1c         = req_wdat;
        REG_ENABLE:  enable_next = (enable & ~req_lane) | req_wdat;
        REG_MODE:    mode_next   = (mode & ~req_lane) | req_wdat;
        default:     ;
      endcase
    end
    rise         = sources & ~prev;
    mode_chg     = mode ^ mode_next;
    // Set beats clear: a new edge survives a same-cycle W1C or claim.
    pending_edge = (pending & ~(w1c | (claim_set & mode))) | rise;
    pending_next = ((mode & pending_edge) | (~mode & sources)) & ~mode_chg;
    in_service_next = (in_service | claim_set) & ~complete_clr;
    irq_next     = |(pending_next & enable_next & ~in_service_next);
  end

  // Register file, edge-detect history and the irq output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      enable     <= '0;
      mode       <= '0;
      in_service <= '0;
      prev       <= '0;
      irq        <= 1'b0;
    end else begin
      pending    <= pending_next;
      enable     <= enable_next;
      mode       <= mode_next;
      in_service <= in_service_next;
      prev       <= sources;
      irq        <= irq_next;
    end
  end

  // Read data is driven during the ack cycle only.
  always_comb begin
    rdata = '0;
    if (req_valid && !req_we) begin
      case (req_reg)
        REG_PENDING:   rdata = 32'(pending);
        REG_ENABLE:    rdata = 32'(enable);
        REG_MODE:      rdata = 32'(mode);
        REG_CLAIM:     rdata = 32'(claim_id);
        REG_INSERVICE: rdata = 32'(in_service);
        default:       rdata = '0;
      endcase
    end
  end

  assign wishbone.ack   = req_valid;
  assign wishbone.err   = 1'b0;
  assign wishbone.dat_r = rdata;

endmodule

// File: tb/tb_wishbone_irq_controller.sv
// Self-checking bench for wishbone_irq_controller: directed scenarios plus a
// randomized phase, all compared against a per-source behavioural model.
module tb_wishbone_irq_controller;
  import wishbone_irq_controller_pkg::*;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] sources = '0;
  logic         irq;
  bit           rand_src = 1'b0;

  wishbone_interface wb();

  wishbone_irq_controller #(
    .ADDRESS     (BASE),
    .SIZE        (IRQC_SIZE),
    .NUM_SOURCES (N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sources  (sources),
    .irq      (irq),
    .wishbone (wb)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: one entry per source, updated per clock from the rules.
  bit m_pend[N], m_en[N], m_mode[N], m_svc[N], m_prev[N];
  bit m_irq, m_ack;

  // Bus operation whose effect lands at the end of the current (ack) cycle.
  bit          op_valid = 1'b0;
  bit          op_we;
  logic [31:0] op_off, op_dat;
  logic [3:0]  op_sel;

  function automatic int m_claim_id();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i] && !m_svc[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] off);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case (off)
        32'h00: r[i] = m_pend[i];
        32'h04: r[i] = m_en[i];
        32'h08: r[i] = m_mode[i];
        32'h10: r[i] = m_svc[i];
        default: ;
      endcase
    end
    if (off == 32'h0C) r = m_claim_id();
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_step
    bit np[N], ne[N], nm[N], ns[N];
    bit rise, any;
    int cid, id;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_mode[i] = 0; m_svc[i] = 0; m_prev[i] = 0;
      end
      m_irq = 0;
      m_ack = 0;
    end else begin
      ne = m_en; nm = m_mode; ns = m_svc; cid = 0;
      if (op_valid && op_we) begin
        for (int i = 0; i < N; i++) begin
          if (op_off == 32'h04 && op_sel[i / 8]) ne[i] = op_dat[i];
          if (op_off == 32'h08 && op_sel[i / 8]) nm[i] = op_dat[i];
        end
        id = int'(op_dat[4:0]);
        if (op_off == 32'h0C && op_sel[0] && id >= 1 && id <= N)
          if (m_svc[id - 1]) ns[id - 1] = 0;
      end else if (op_valid && op_off == 32'h0C) begin
        cid = m_claim_id();
        if (cid != 0) ns[cid - 1] = 1;
      end
      any = 0;
      for (int i = 0; i < N; i++) begin
        rise = sources[i] && !m_prev[i];
        if (nm[i] != m_mode[i]) np[i] = 0;
        else if (m_mode[i]) begin
          np[i] = m_pend[i];
          if (op_valid && op_we && op_off == 32'h00 && op_sel[i / 8] && op_dat[i]) np[i] = 0;
          if (cid == i + 1) np[i] = 0;
          if (rise) np[i] = 1;
        end else np[i] = sources[i];
        m_prev[i] = sources[i];
        if (np[i] && ne[i] && !ns[i]) any = 1;
      end
      m_pend = np; m_en = ne; m_mode = nm; m_svc = ns;
      m_irq = any;
      m_ack = wb.cyc && wb.stb;
    end
  end

  // Cycle-by-cycle output checks away from the active edge.
  always @(negedge clk) begin
    check_eq("irq", 32'(irq), 32'(m_irq));
    check_eq("ack", 32'(wb.ack), 32'(m_ack));
    check_eq("err", 32'(wb.err), 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_src) sources = N'($urandom);
  endtask

  task automatic wb_xfer(input bit we, input logic [31:0] off, input logic [31:0] dat,
                         input logic [3:0] sel, input bit chg_src, input logic [N-1:0] new_src,
                         output logic [31:0] rdata);
    wb.cyc = 1; wb.stb = 1; wb.we = we; wb.adr = BASE + off; wb.dat_w = dat; wb.sel = sel;
    tick();
    wb.cyc = 0; wb.stb = 0; wb.we = 0;
    if (chg_src) sources = new_src;
    check_eq("ack_cycle", 32'(wb.ack), 32'h1);
    rdata = wb.dat_r;
    if (!we) check_eq("rd_model", rdata, m_read(off));
    op_valid = 1; op_we = we; op_off = off; op_dat = dat; op_sel = sel;
    tick();
    op_valid = 0;
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
    logic [31:0] unused_r;
    wb_xfer(1'b1, off, dat, sel, 1'b0, '0, unused_r);
  endtask

  task automatic wb_read_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, off, 32'h0, 4'hF, 1'b0, '0, r);
    check_eq(tag, r, exp);
  endtask

  initial begin
    logic [31:0] r, off, dat;
    logic [3:0]  sel;
    bit          we;

    wb.cyc = 0; wb.stb = 0; wb.we = 0; wb.adr = '0; wb.dat_w = '0; wb.sel = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick();

    // Reset asserted in the middle of a CLAIM read with irq active.
    wb_write(IRQC_ENABLE, 32'h01);
    sources = 8'h01;
    tick();
    check_eq("pre_rst_irq", 32'(irq), 32'h1);
    wb.cyc = 1; wb.stb = 1; wb.we = 0; wb.adr = BASE + IRQC_CLAIM; wb.sel = 4'hF;
    @(posedge clk);
    #2 rst_n = 0;
    wb.cyc = 0; wb.stb = 0; sources = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ack", 32'(wb.ack), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    rst_n = 1;
    tick();
    wb_read_chk("rst_pending", IRQC_PENDING, 32'h0);
    wb_read_chk("rst_enable", IRQC_ENABLE, 32'h0);
    wb_read_chk("rst_mode", IRQC_MODE, 32'h0);
    wb_read_chk("rst_claim", IRQC_CLAIM, 32'h0);
    wb_read_chk("rst_insvc", IRQC_INSERVICE, 32'h0);
    wb_read_chk("unmapped", 32'h14, 32'h0);

    // Level mode.
    wb_write(IRQC_ENABLE, 32'h01);
    sources = 8'h01;
    tick();
    check_eq("lvl_irq", 32'(irq), 32'h1);
    wb_read_chk("lvl_claim", IRQC_CLAIM, 32'h1);
    check_eq("lvl_masked", 32'(irq), 32'h0);
    wb_write(IRQC_CLAIM, 32'h1);
    check_eq("lvl_back", 32'(irq), 32'h1);
    sources = '0;
    tick();
    tick();
    check_eq("lvl_low", 32'(irq), 32'h0);
    wb_write(IRQC_ENABLE, 32'h0);

    // Edge mode.
    wb_write(IRQC_MODE, 32'h04);
    wb_write(IRQC_ENABLE, 32'h04);
    sources = 8'h04;
    tick();
    sources = '0;
    check_eq("edge_irq", 32'(irq), 32'h1);
    wb_read_chk("edge_pend", IRQC_PENDING, 32'h04);
    wb_read_chk("edge_claim", IRQC_CLAIM, 32'h3);
    wb_read_chk("edge_pend_clr", IRQC_PENDING, 32'h0);
    wb_xfer(1'b1, IRQC_PENDING, 32'h04, 4'hF, 1'b1, 8'h04, r);
    sources = '0;
    wb_read_chk("set_wins", IRQC_PENDING, 32'h04);
    wb_write(IRQC_PENDING, 32'h04);
    wb_read_chk("w1c", IRQC_PENDING, 32'h0);
    wb_write(IRQC_CLAIM, 32'h3);

    // Priority between sources 1 and 5.
    wb_write(IRQC_MODE, 32'h26);
    wb_write(IRQC_ENABLE, 32'h22);
    sources = 8'h22;
    tick();
    sources = '0;
    wb_read_chk("prio_1st", IRQC_CLAIM, 32'h2);
    wb_read_chk("prio_2nd", IRQC_CLAIM, 32'h6);
    wb_read_chk("prio_3rd", IRQC_CLAIM, 32'h0);
    wb_read_chk("prio_insvc", IRQC_INSERVICE, 32'h22);

    // Bogus completes leave IN_SERVICE untouched.
    wb_write(IRQC_CLAIM, 32'h0);
    wb_write(IRQC_CLAIM, 32'(N + 1));
    wb_write(IRQC_CLAIM, 32'h4);
    wb_read_chk("bogus_insvc", IRQC_INSERVICE, 32'h22);
    wb_write(IRQC_CLAIM, 32'h2);
    wb_write(IRQC_CLAIM, 32'h6);
    wb_read_chk("done_insvc", IRQC_INSERVICE, 32'h0);

    // Byte selects.
    wb_write(IRQC_ENABLE, 32'hFFFF_FFFF, 4'b0001);
    wb_read_chk("sel_lane0", IRQC_ENABLE, 32'h0000_00FF);
    wb_write(IRQC_ENABLE, 32'h0, 4'b0010);
    wb_read_chk("sel_lane1", IRQC_ENABLE, 32'h0000_00FF);
    wb_write(IRQC_ENABLE, 32'h0);
    wb_write(IRQC_MODE, 32'h0);

    // Randomized traffic against the model.
    rand_src = 1;
    for (int k = 0; k < 500; k++) begin
      off = 32'($urandom_range(0, 7)) * 4;
      we  = 1'($urandom_range(0, 1));
      dat = (off == IRQC_CLAIM) ? 32'($urandom_range(0, 10)) : $urandom;
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      wb_xfer(we, off, dat, sel, 1'b0, '0, r);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_src = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_irq_controller.md
# wishbone_irq_controller

Parametrised interrupt controller for the MCU peripheral bus. It aggregates `NUM_SOURCES` interrupt lines into one `irq` output for the CPU's external-interrupt input, replacing the fixed OR of peripheral interrupts. Each source has its own enable, edge/level mode, pending tracking and claim/complete handshake. The block is one wishbone slave on the memory-bus interconnect.

## Interface
- `ADDRESS`, 32'h0, base byte address of the register window.
- `SIZE`, 32'h20, window size in bytes; accesses are decoded on `adr - ADDRESS`.
- `NUM_SOURCES`, 8, number of interrupt inputs; legal range 1..31.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `sources`  in  NUM_SOURCES  interrupt requests, already synchronous to `clk`, active-high.
- `irq`  out  1  registered interrupt request to the CPU.
- `wishbone`  slave  wishbone_interface  register access port.

## Operation
- Register map (word offsets; bits at or above NUM_SOURCES read 0 and ignore writes):
  - 0x00 PENDING: RW1C.
  - 0x04 ENABLE: RW.
  - 0x08 MODE: RW; 1 = edge, 0 = level.
  - 0x0C CLAIM: read = claim, write = complete.
  - 0x10 IN_SERVICE: RO.
- Edge source i:
  - A rising edge (`sources[i]` = 1 with previous sample 0) sets `pending[i]`.
  - PENDING write 1 clears it.
  - If set and clear hit the same cycle, set wins.
- Level source i: `pending[i]` is loaded with `sources[i]` every cycle. PENDING writes have no effect.
- Eligible vector: `pending & enable & ~in_service`.
- `irq` <= OR of the eligible vector, registered.
- CLAIM read:
  - Returns id = (lowest-index eligible source) + 1, or 0 if none are eligible.
  - If id ≠ 0, the same cycle the ack is issued: set `in_service[id-1]`; if that source is edge mode, also clear `pending[id-1]`.
- CLAIM write (complete):
  - Takes `dat[4:0]` = id and clears `in_service[id-1]`.
  - Ignored if id = 0, id > NUM_SOURCES, or the source is not in service.
- Writes honour `sel` per byte lane.
- Unmapped offsets inside the window: ack, read 0, write ignored.
- Changing MODE clears `pending[i]` for every bit that changed, so there are no spurious edges.
- Disabled sources still latch pending; they assert `irq` once enabled.
- Reset values:
  - pending, enable, mode, in_service, previous-sample register: all 0.
  - `irq` 0; ack 0; err 0.
- Reset asserted mid-transaction: the transaction is dropped, no ack follows, all state returns to reset values.

## Timing
- Bus:
  - The slave never stalls.
  - `ack` is asserted exactly one cycle after a cycle with `cyc & stb`, for one cycle.
  - Read data is valid with `ack`.
  - Back-to-back requests are acked on consecutive cycles.
- `err` is never asserted.
- Source rising edge at cycle N:
  - `pending` is set at the end of N.
  - `irq` is high at N+1 if the source is eligible.
- Register write acked at cycle N: effect visible to a read issued at N+1; `irq` reflects it at N+1.
- CLAIM read: the claimed source is masked from `irq` starting the cycle after the ack.
- Simultaneous events:
  - CLAIM read and a new edge on the claimed source in the same cycle: pending stays set (set wins); the source remains in service.
  - Complete and claim of the same id cannot coincide because there is a single port.

## Structure
- The shared constants package gets:
  - `IRQC_START` and `IRQC_SIZE` (address map).
  - Register offset localparams `IRQC_PENDING`, `IRQC_ENABLE`, `IRQC_MODE`, `IRQC_CLAIM`, `IRQC_INSERVICE`.
- One sub-module, `irq_priority_encoder`:
  - Combinational lowest-index-first encoder, parameterised by width.
  - Output is a 1-based id with a zero-means-none convention.
- The wishbone decode, register file, edge detect and `irq` register are in the top module.
- In the MCU, `uart_interrupt` and `test_interrupt` connect to `sources[1:0]`.

## Test plan
- Reset: hold `rst_n` = 0 mid-read → `ack` and `irq` stay 0. After release, all registers read 0.
- Level mode:
  - Setup: ENABLE = 0x01, MODE = 0, `sources[0]` = 1.
  - → `irq` = 1 one cycle later.
  - CLAIM read returns 1 and `irq` drops.
  - Complete(1) while the source is still high → `irq` returns next cycle.
- Edge mode:
  - Setup: MODE = 0x04, ENABLE = 0x04, one-cycle pulse on `sources[2]`.
  - → PENDING = 0x04 and `irq` = 1.
  - CLAIM returns 3 and PENDING = 0.
  - A PENDING write of 0x04 issued in the same cycle as a new pulse leaves PENDING = 0x04.
- Priority:
  - Setup: sources 5 and 1 pending and enabled.
  - → first CLAIM returns 2, second returns 6, third returns 0; IN_SERVICE = 0x22.
- Bogus complete: complete(0), complete(NUM_SOURCES+1) and complete of a non-serviced id → IN_SERVICE unchanged; each is acked in exactly one cycle.
- Byte-select: write ENABLE = 0xFFFF_FFFF with `sel` = 0b0001 and NUM_SOURCES = 8 → ENABLE reads 0x0000_00FF.
